// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the NEC infrared receiver.
//   - ir_state_t : receiver FSM states
//   - *_US       : protocol timing limits in microseconds
//   - us2cyc()   : converts a microsecond limit to clock cycles
//   - FILT_CNT_W : width of the glitch filter run-length counter
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_LO,
        ST_LEAD_HI,
        ST_BIT_LO,
        ST_BIT_HI
    } ir_state_t;

    localparam longint unsigned LEAD_LO_MIN_US  = 64'd7400;
    localparam longint unsigned LEAD_HI_MIN_US  = 64'd3700;
    localparam longint unsigned RPT_HI_MIN_US   = 64'd1800;
    localparam longint unsigned LEAD_HI_MAX_US  = 64'd5900;
    localparam longint unsigned BIT_LO_MAX_US   = 64'd1000;
    localparam longint unsigned BIT_MIN_HI_US   = 64'd280;
    localparam longint unsigned BIT_ONE_HI_US   = 64'd1000;
    localparam longint unsigned DATA_HI_MAX_US  = 64'd5240;
    localparam longint unsigned RELEASE_US      = 64'd120000;

    localparam int FILT_CNT_W = 8;

    // Integer division on the kHz value first keeps the intermediate
    // product small and matches the documented rounding.
    function automatic longint unsigned us2cyc(input longint unsigned freq,
                                               input longint unsigned us);
        return (freq / 64'd1000) * us / 64'd1000;
    endfunction

endpackage

// File: rtl/ir_glitch_filter.sv
// ir_glitch_filter: 2-FF synchroniser followed by a run-length filter.
// The output only changes after FILT_LEN consecutive synchronised samples
// disagree with it, so latency from din to dout is 2 + FILT_LEN cycles.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   din   in  raw asynchronous input (idle high)
//   dout  out filtered level, resets to idle-high
module ir_glitch_filter
    import ir_pkg::*;
#(
    parameter int unsigned FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam logic [FILT_CNT_W-1:0] RUN_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic                  sync1;
    logic                  sync2;
    logic [FILT_CNT_W-1:0] run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            run   <= '0;
            dout  <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                run <= '0;
            end else if (run == RUN_LAST) begin
                dout <= sync2;
                run  <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_nec_rcv.sv
// ir_nec_rcv: NEC / extended-NEC infrared frame receiver.
// Ports:
//   clk27      in   system clock (frequency given by CLK_FREQ_HZ)
//   reset_n    in   asynchronous active-low reset
//   ir_rx      in   raw demodulator output, active-low, asynchronous
//   ir_addr    out  held address ({~addr, addr} or 16-bit extended)
//   ir_cmd     out  held command byte
//   ir_ext     out  held frame was extended format
//   ir_held    out  a code is currently held
//   ir_valid   out  1-cycle pulse, new frame accepted
//   ir_rpt     out  1-cycle pulse, repeat accepted while held
//   ir_rpt_cnt out  repeats since last frame, saturating at 255
//   ir_err     out  1-cycle pulse, frame aborted
//
// state      | meaning
// ST_IDLE    | waiting for a falling edge
// ST_LEAD_LO | measuring the 9 ms leader burst
// ST_LEAD_HI | measuring the leader space (frame vs repeat)
// ST_BIT_LO  | data bit burst
// ST_BIT_HI  | data bit space, its length encodes the bit
module ir_nec_rcv
    import ir_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27000000,
    parameter int unsigned FILT_LEN    = 8,
    parameter bit          EXT_ADDR_EN = 1'b1,
    parameter int unsigned CNT_W       = 24
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        ir_rx,
    output logic [15:0] ir_addr,
    output logic [7:0]  ir_cmd,
    output logic        ir_ext,
    output logic        ir_held,
    output logic        ir_valid,
    output logic        ir_rpt,
    output logic [7:0]  ir_rpt_cnt,
    output logic        ir_err
);

    localparam longint unsigned F = 64'(CLK_FREQ_HZ);
    localparam logic [CNT_W-1:0] T_LEAD_LO_MIN = CNT_W'(us2cyc(F, LEAD_LO_MIN_US));
    localparam logic [CNT_W-1:0] T_LEAD_HI_MIN = CNT_W'(us2cyc(F, LEAD_HI_MIN_US));
    localparam logic [CNT_W-1:0] T_RPT_HI_MIN  = CNT_W'(us2cyc(F, RPT_HI_MIN_US));
    localparam logic [CNT_W-1:0] T_LEAD_HI_MAX = CNT_W'(us2cyc(F, LEAD_HI_MAX_US));
    localparam logic [CNT_W-1:0] T_BIT_LO_MAX  = CNT_W'(us2cyc(F, BIT_LO_MAX_US));
    localparam logic [CNT_W-1:0] T_BIT_MIN_HI  = CNT_W'(us2cyc(F, BIT_MIN_HI_US));
    localparam logic [CNT_W-1:0] T_BIT_ONE_HI  = CNT_W'(us2cyc(F, BIT_ONE_HI_US));
    localparam logic [CNT_W-1:0] T_DATA_HI_MAX = CNT_W'(us2cyc(F, DATA_HI_MAX_US));
    localparam logic [CNT_W-1:0] T_RELEASE     = CNT_W'(us2cyc(F, RELEASE_US));
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;

    logic             rx_f;
    logic             rx_d;
    logic             rise;
    logic             fall;
    ir_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rel_cnt;
    logic [4:0]       bit_cnt;
    // Only the 31 earlier bits are stored; the 32nd is checked as it arrives.
    logic [30:0]      shreg;
    logic             bit_val;
    logic [31:0]      word;
    logic             addr_pair_ok;
    logic             check_ok;
    logic             rpt_hit;
    logic             frame_hit;
    logic             release_hit;

    ir_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk   (clk27),
        .rst_n (reset_n),
        .din   (ir_rx),
        .dout  (rx_f)
    );

    assign rise         = rx_f & ~rx_d;
    assign fall         = ~rx_f & rx_d;
    assign bit_val      = (cnt >= T_BIT_ONE_HI);
    assign word         = {bit_val, shreg};
    assign addr_pair_ok = (word[7:0] == ~word[15:8]);
    assign check_ok     = (word[23:16] == ~word[31:24]) && (addr_pair_ok || EXT_ADDR_EN);

    assign rpt_hit   = (state == ST_LEAD_HI) && fall && ir_held &&
                       (cnt >= T_RPT_HI_MIN) && (cnt < T_LEAD_HI_MIN);
    assign frame_hit = (state == ST_BIT_HI) && fall && (cnt >= T_BIT_MIN_HI) &&
                       (bit_cnt == 5'd31) && check_ok;
    // A new frame or repeat in the expiry cycle keeps the code held.
    assign release_hit = ir_held && (rel_cnt >= T_RELEASE) && !rpt_hit && !frame_hit;

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rx_d       <= 1'b1;
            cnt        <= '0;
            rel_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            ir_addr    <= '0;
            ir_cmd     <= '0;
            ir_ext     <= 1'b0;
            ir_held    <= 1'b0;
            ir_valid   <= 1'b0;
            ir_rpt     <= 1'b0;
            ir_rpt_cnt <= '0;
            ir_err     <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            ir_rpt   <= 1'b0;
            ir_err   <= 1'b0;
            rx_d     <= rx_f;

            if (rise || fall) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (rel_cnt != CNT_MAX) begin
                rel_cnt <= rel_cnt + 1'b1;
            end

            if (release_hit) begin
                ir_held    <= 1'b0;
                ir_addr    <= '0;
                ir_cmd     <= '0;
                ir_ext     <= 1'b0;
                ir_rpt_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state <= ST_LEAD_LO;
                    end
                end
                ST_LEAD_LO: begin
                    if (rise) begin
                        state <= (cnt >= T_LEAD_LO_MIN) ? ST_LEAD_HI : ST_IDLE;
                    end
                end
                ST_LEAD_HI: begin
                    if (fall) begin
                        if (cnt >= T_LEAD_HI_MIN) begin
                            state   <= ST_BIT_LO;
                            bit_cnt <= '0;
                            shreg   <= '0;
                        end else begin
                            state <= ST_IDLE;
                            if (rpt_hit) begin
                                ir_rpt  <= 1'b1;
                                rel_cnt <= '0;
                                if (ir_rpt_cnt != 8'hFF) begin
                                    ir_rpt_cnt <= ir_rpt_cnt + 8'd1;
                                end
                            end
                        end
                    end else if (cnt > T_LEAD_HI_MAX) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                ST_BIT_LO: begin
                    if (cnt > T_BIT_LO_MAX) begin
                        ir_err <= 1'b1;
                        state  <= ST_IDLE;
                        cnt    <= '0;
                    end else if (rise) begin
                        state <= ST_BIT_HI;
                    end
                end
                ST_BIT_HI: begin
                    if (fall) begin
                        if (cnt < T_BIT_MIN_HI) begin
                            ir_err <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            shreg   <= word[31:1];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) begin
                                state <= ST_IDLE;
                                if (check_ok) begin
                                    ir_addr    <= word[15:0];
                                    ir_cmd     <= word[23:16];
                                    ir_ext     <= !addr_pair_ok;
                                    ir_held    <= 1'b1;
                                    ir_rpt_cnt <= '0;
                                    ir_valid   <= 1'b1;
                                    rel_cnt    <= '0;
                                end else begin
                                    ir_err <= 1'b1;
                                end
                            end else begin
                                state <= ST_BIT_LO;
                            end
                        end
                    end else if (cnt > T_DATA_HI_MAX) begin
                        ir_err <= 1'b1;
                        state  <= ST_IDLE;
                        cnt    <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
